operand_fifo: RTL and testbench
===============================

OPERAND_FIFO -- requirements
Module: operand_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand width in bits, equal to the adder's DATA_IN_WIDTH.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; legal values are powers of two, 2 or more.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_data, input, DATA_WIDTH bits: operand written by the producer.
REQ-006 SHALL have port in_valid, input, 1 bit: producer presents in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: FIFO accepts a write this cycle.
REQ-008 SHALL have port out_data, output, DATA_WIDTH bits: head entry; drives adder in_A or in_B.
REQ-009 SHALL have port out_valid, output, 1 bit: head entry is valid; drives adder in_A_valid or in_B_valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the head; driven by adder in_A_ready or in_B_ready.

Function
REQ-011 SHALL push when in_valid and in_ready are both 1 at a rising edge, and SHALL pop when out_valid and out_ready are both 1 at a rising edge.
REQ-012 SHALL keep read and write pointers of log2(DEPTH)+1 bits each; the MSB is the wrap bit and the pointers increment modulo 2*DEPTH.
REQ-013 SHALL flag empty when the pointers are equal, and full when the low bits are equal and the wrap bits differ.
REQ-014 SHALL drive in_ready = not full AND rst_done.
REQ-015 SHALL drive out_valid = not empty.
REQ-016 SHALL drive out_data = mem[rd_ptr low bits], first-word-fall-through, with no output register.
REQ-017 SHALL raise out_valid exactly 1 cycle after the edge of a push into an empty FIFO; there is no combinational in-to-out bypass.
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL perform a push and a pop in the same cycle when both are legal, leaving the occupancy unchanged.
REQ-020 SHALL accept no push when full, even if a pop occurs in the same cycle, so in_ready depends only on registered state.
REQ-021 SHALL make no state change on in_valid=1 while in_ready=0, or on out_ready=1 while out_valid=0.
REQ-022 SHALL preserve data order across pointer wrap-around with no loss or duplication.

Reset
REQ-023 SHALL, while arst_n=0, asynchronously force: both pointers to 0, every memory entry to 0, and rst_done to 0.
REQ-024 SHALL, in consequence of REQ-023, drive out_valid=0, out_data=0 and in_ready=0 during reset.
REQ-025 SHALL set rst_done to 1 at the first rising edge after arst_n deasserts, so in_ready becomes 1 from that cycle.
REQ-026 SHALL, if arst_n asserts mid-operation, discard all stored entries immediately and apply the REQ-023 values.

Configuration
REQ-027 SHALL, when OPERAND_FIFO_COUNT_EN is defined, add output port count of log2(DEPTH)+1 bits, equal to wr_ptr minus rd_ptr modulo 2*DEPTH; its reset value is 0 and it is updated with the pointers.
REQ-028 SHALL, when OPERAND_FIFO_COUNT_EN is undefined, omit the count port and its logic, with all other behaviour identical.

Verification (DATA_WIDTH=8, DEPTH=4)
REQ-029 SHALL cover reset release: arst_n low, then high -> in_ready=0 and out_valid=0 during reset; in_ready=1 at the first edge after release; out_data=0x00.
REQ-030 SHALL cover fill then drain: push 0x11, 0x22, 0x33, 0x44 with out_ready=0 -> in_ready=0 after the 4th push and count=4; then hold out_ready=1 -> pops 0x11, 0x22, 0x33, 0x44 in order, then out_valid=0.
REQ-031 SHALL cover full with simultaneous request: FIFO full, in_valid=1 with 0x55, out_ready=1 -> 0x11 pops and 0x55 is not accepted; in_ready=1 the next cycle.
REQ-032 SHALL cover steady streaming and wrap: 10 consecutive cycles with in_valid=1 and out_ready=1, data 0x00 to 0x09 -> output 0x00 to 0x09 in order, count constant at 1 after the first cycle, and pointers wrapping correctly.
REQ-033 SHALL cover two FIFOs driving an adder, with the A FIFO holding 0xFF, the B FIFO empty, and out_ready=1 -> the A entry is held; after 0x01 is pushed into B, both pop in the same cycle and adder out=0x100.
REQ-034 SHALL cover reset mid-operation: 3 entries stored, arst_n pulsed low for 1 ns between edges -> out_valid=0 and count=0 immediately; the old data never reappears.

Source files
------------

// File: rtl/operand_fifo.sv
// Operand FIFO: first-word-fall-through queue feeding one adder operand (build option OPERAND_FIFO_COUNT_EN adds the count port).
// Latency: out_valid rises one cycle after a push into an empty FIFO; out_data comes straight from storage, no bypass.
// Backpressure: in_ready drops when full (registered state only, a same-cycle pop does not free a slot); head held while out_ready=0.
`timescale 1ns/100ps
module operand_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    arst_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef OPERAND_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]  count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rst_done;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Status flags from the wrap-bit pointer comparison; handshakes qualify the pointer moves.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        in_ready  = !full && rst_done;
        out_valid = !empty;
        out_data  = mem[rd_ptr[AW-1:0]];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Pointers advance modulo 2*DEPTH; rst_done gates writes until the first edge after reset release.
    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage is cleared on reset so out_data reads zero and old operands can never resurface.
    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

`ifdef OPERAND_FIFO_COUNT_EN
    // Occupancy follows the registered pointers; the modulo subtraction handles wrap for free.
    always_comb begin
        count = wr_ptr - rd_ptr;
    end
`endif

endmodule

// File: tb/tb_operand_fifo.sv
// Bench for operand_fifo: queue model checked every cycle plus directed literal checks.
// Drives inputs 1 ns after the rising edge, samples on the falling edge.
// A second instance acts as the B operand for the adder-join scenario.
`timescale 1ns/100ps
module tb_operand_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk_i;
    logic          arst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          adder_en;
    logic          a_ready;

    logic [DW-1:0] b_in_data;
    logic          b_in_valid;
    logic          b_in_ready;
    logic [DW-1:0] b_out_data;
    logic          b_out_valid;
    logic          b_ready;

`ifdef OPERAND_FIFO_COUNT_EN
    logic [2:0]    count;
    logic [2:0]    b_count;
`endif

    // The adder only consumes when both operands are present.
    assign a_ready = adder_en ? (out_valid && b_out_valid) : out_ready;
    assign b_ready = adder_en ? (out_valid && b_out_valid) : 1'b0;

    operand_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i     (clk_i),
        .arst_n    (arst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (a_ready)
`ifdef OPERAND_FIFO_COUNT_EN
        ,
        .count     (count)
`endif
    );

    operand_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fifo_b (
        .clk_i     (clk_i),
        .arst_n    (arst_n),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_ready)
`ifdef OPERAND_FIFO_COUNT_EN
        ,
        .count     (b_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model: a plain queue with the handshake rules applied to it.
    logic [DW-1:0] m_q [$];
    logic          m_rst_done = 1'b0;
    logic [DW-1:0] got [$];

    always @(posedge clk_i) begin
        bit do_push;
        bit do_pop;
        if (arst_n) begin
            do_push = in_valid && m_rst_done && (m_q.size() < DEPTH);
            do_pop  = (m_q.size() > 0) && a_ready;
            if (do_pop) begin
                void'(m_q.pop_front());
            end
            if (do_push) begin
                m_q.push_back(in_data);
            end
            m_rst_done = 1'b1;
        end
    end

    always @(negedge arst_n) begin
        m_q.delete();
        m_rst_done = 1'b0;
    end

    // Log of everything the A FIFO actually delivered.
    always @(posedge clk_i) begin
        if (arst_n && out_valid && a_ready) begin
            got.push_back(out_data);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_i) begin
        check("model_in_ready", 32'(in_ready), 32'(m_rst_done && (m_q.size() < DEPTH)));
        check("model_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("model_out_data", 32'(out_data), 32'(m_q[0]));
        end else if (!arst_n) begin
            check("model_rst_data", 32'(out_data), 32'h0);
        end
`ifdef OPERAND_FIFO_COUNT_EN
        check("model_count", 32'(count), 32'(m_q.size()));
`endif
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        arst_n     = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        adder_en   = 1'b0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        #1 arst_n = 1'b0;
        #1;
        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        repeat (2) @(posedge clk_i);
        #2 arst_n = 1'b1;
        cyc();
        check("rel_in_ready", 32'(in_ready), 32'h1);
        check("rel_out_data", 32'(out_data), 32'h0);

        // Fill with consumer stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h11 * (i + 1));
            cyc();
        end
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_head", 32'(out_data), 32'h11);
`ifdef OPERAND_FIFO_COUNT_EN
        check("full_count", 32'(count), 32'h4);
`endif

        // Full with simultaneous push and pop: pop only
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("fullpop_in_ready", 32'(in_ready), 32'h1);
        check("fullpop_head", 32'(out_data), 32'h22);
        repeat (3) cyc();
        out_ready = 1'b0;
        check("drain_out_valid", 32'(out_valid), 32'h0);
        check("drain_len", 32'(got.size()), 32'h4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            check("drain_order", 32'(got[i]), 32'(8'h11 * (i + 1)));
        end

        // Streaming across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            cyc();
            check("stream_valid", 32'(out_valid), 32'h1);
`ifdef OPERAND_FIFO_COUNT_EN
            check("stream_count", 32'(count), 32'h1);
`endif
        end
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        check("stream_len", 32'(got.size()), 32'd14);
        for (int i = 0; i < 10 && (i + 4) < got.size(); i++) begin
            check("stream_order", 32'(got[i + 4]), 32'(i));
        end

        // Adder join: A waits for B
        adder_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        check("join_a_held_valid", 32'(out_valid), 32'h1);
        check("join_a_held_data", 32'(out_data), 32'hFF);
        b_in_valid = 1'b1;
        b_in_data  = 8'h01;
        cyc();
        b_in_valid = 1'b0;
        check("join_b_valid", 32'(b_out_valid), 32'h1);
        check("join_sum", 32'({1'b0, out_data} + {1'b0, b_out_data}), 32'h100);
        cyc();
        check("join_a_popped", 32'(out_valid), 32'h0);
        check("join_b_popped", 32'(b_out_valid), 32'h0);
        adder_en = 1'b0;

        // Reset pulse while holding three entries
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA1 + i);
            cyc();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        #2 arst_n = 1'b0;
        #0.5;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h0);
        check("mid_rst_data", 32'(out_data), 32'h0);
`ifdef OPERAND_FIFO_COUNT_EN
        check("mid_rst_count", 32'(count), 32'h0);
`endif
        #0.5 arst_n = 1'b1;
        check("post_rst_valid", 32'(out_valid), 32'h0);
        out_ready = 1'b1;
        cyc();
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        repeat (3) cyc();
        check("no_old_data", 32'(got.size()), 32'd15);
        out_ready = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
